// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares one read-first synchronous RAM between requester A (CPU)
// and requester B (DMA/loader); one access per grant, completion signalled by RValidA/RValidB.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic                  ReqA,
    input  logic                  ReqB,
    input  logic [ADDR_WIDTH-1:0] AddrA,
    input  logic [ADDR_WIDTH-1:0] AddrB,
    input  logic [DATA_WIDTH-1:0] WDataA,
    input  logic [DATA_WIDTH-1:0] WDataB,
    input  logic                  WeA,
    input  logic                  WeB,
    output logic                  GntA,
    output logic                  GntB,
    output logic                  RValidA,
    output logic                  RValidB,
    output logic [DATA_WIDTH-1:0] RData,
    output logic [ADDR_WIDTH-1:0] RamAddrIn,
    output logic [ADDR_WIDTH-1:0] RamAddrOut,
    output logic [DATA_WIDTH-1:0] RamDataIn,
    output logic                  RamWriteEnable,
    input  logic [DATA_WIDTH-1:0] RamDataOut,
    output logic [1:0]            DbgState
);

    // Handshake: a requester raises Req with Addr/WData/We stable and holds them until it
    // sees Gnt; Req & Gnt at a rising edge is the accept. Gnt may only be high in IDLE or
    // CAPTURE, so at most one access is in flight. RValid pulses for one cycle two edges
    // after the accept, carrying the RAM read data (old contents for a write).

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_addr_q;
    logic [DATA_WIDTH-1:0]   r_wdata_q;
    logic                    r_we_q;
    logic                    r_owner_q;
    logic                    r_last_owner;
    logic                    r_ram_we;
    logic                    r_rvalid_a;
    logic                    r_rvalid_b;

    logic                    w_can_grant;
    logic                    w_gnt_a;
    logic                    w_gnt_b;
    logic                    w_accept_a;
    logic                    w_accept_b;
    logic                    w_accept;

    // On a tie the requester that did not own the previous access wins.
    assign w_can_grant = ResetN && ((r_state == IDLE) || (r_state == CAPTURE));
    assign w_gnt_a     = w_can_grant && ReqA && (!ReqB || (r_last_owner == OWNER_B));
    assign w_gnt_b     = w_can_grant && ReqB && (!ReqA || (r_last_owner == OWNER_A));
    assign w_accept_a  = w_gnt_a && ReqA;
    assign w_accept_b  = w_gnt_b && ReqB;
    assign w_accept    = w_accept_a || w_accept_b;

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            r_state      <= IDLE;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_we_q       <= 1'b0;
            r_owner_q    <= OWNER_A;
            r_last_owner <= OWNER_B;
            r_ram_we     <= 1'b0;
            r_rvalid_a   <= 1'b0;
            r_rvalid_b   <= 1'b0;
        end else begin
            r_ram_we   <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            case (r_state)
                IDLE, CAPTURE: begin
                    if (w_accept) begin
                        r_addr_q     <= w_accept_a ? AddrA  : AddrB;
                        r_wdata_q    <= w_accept_a ? WDataA : WDataB;
                        r_we_q       <= w_accept_a ? WeA    : WeB;
                        r_owner_q    <= w_accept_a ? OWNER_A : OWNER_B;
                        r_last_owner <= w_accept_a ? OWNER_A : OWNER_B;
                        r_ram_we     <= w_accept_a ? WeA    : WeB;
                        r_state      <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_rvalid_a <= (r_owner_q == OWNER_A);
                    r_rvalid_b <= (r_owner_q == OWNER_B);
                    r_state    <= CAPTURE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ResetN gating drops any in-flight write or completion the moment reset is seen.
    assign GntA           = w_gnt_a;
    assign GntB           = w_gnt_b;
    assign RValidA        = r_rvalid_a && ResetN;
    assign RValidB        = r_rvalid_b && ResetN;
    assign RData          = RamDataOut;
    assign RamAddrIn      = r_addr_q;
    assign RamAddrOut     = r_addr_q;
    assign RamDataIn      = r_wdata_q;
    assign RamWriteEnable = r_ram_we && r_we_q && ResetN;
    assign DbgState       = r_state;

endmodule
